// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_n
// Purpose  : Multi-cycle adder, DIGIT bits per clock through a full-adder
//            chain with a registered carry; valid/ready on both sides.
//            Optional subtract mode enabled by macro SERIAL_ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = $clog2(NSLICE + 1);
    localparam logic [CW-1:0] C_LAST = CW'(NSLICE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_sub;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_slice;
    logic [WIDTH-1:0] w_sum_shift;

    genvar gi;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_n: DIGIT must divide WIDTH and both must be >= 1");
    end

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Ripple chain across one slice; carry-in comes from the carry register
    assign w_c[0] = r_carry;
    for (gi = 0; gi < DIGIT; gi++) begin : g_fa
        assign w_slice[gi] = r_a[gi] ^ r_b[gi] ^ w_c[gi];
        assign w_c[gi+1]   = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
    end

    if (DIGIT == WIDTH) begin : g_single
        assign w_sum_shift = w_slice;
    end else begin : g_multi
        assign w_sum_shift = {w_slice, r_sum[WIDTH-1:DIGIT]};
    end

    assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)         w_state_next = S_RUN;
            S_RUN:   if (r_cnt == C_LAST)  w_state_next = S_DONE;
            S_DONE:  if (out_ready)        w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == S_IDLE);
        end
    end

    // Final RUN cycle (counter at NSLICE) commits the carry register to cout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub ? ~cin : cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            if (r_cnt != C_LAST) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_sum   <= w_sum_shift;
                r_carry <= w_c[DIGIT];
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cout  <= r_carry;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_n
// Purpose  : Randomised self-checking bench for serial_adder_n, one instance
//            with DIGIT=1 and one with DIGIT=4, against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_n;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] cin;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [1:0] cout;
    logic [7:0] a   [2];
    logic [7:0] b   [2];
    logic [7:0] sum [2];
`ifdef SERIAL_ADDER_SUB_EN
    logic [1:0] sub;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .cin(cin[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .cout(cout[0])
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .cin(cin[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .cout(cout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One complete transaction on instance s; hold = cycles of back-pressure
    task automatic do_op(input int s, input logic [7:0] ta, input logic [7:0] tbv,
                         input logic tc, input logic ts, input int hold);
        logic [8:0] exp_r;
        int         n;
        int         lat;
        int         exp_lat;
        exp_lat = (s == 0) ? 9 : 3;
        if (ts)
            exp_r = {1'b0, ta} + {1'b0, ~tbv} + {8'd0, ~tc};
        else
            exp_r = {1'b0, ta} + {1'b0, tbv} + {8'd0, tc};
        n = 0;
        while (!in_ready[s] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq("in_ready_idle", 32'(in_ready[s]), 32'd1);
        a[s] = ta; b[s] = tbv; cin[s] = tc; in_valid[s] = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub[s] = ts;
`endif
        @(posedge clk); #1;
        in_valid[s] = 1'b0;
        check_eq("in_ready_busy", 32'(in_ready[s]), 32'd0);
        lat = 0;
        while (!out_valid[s] && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("sum", 32'(sum[s]), 32'(exp_r[7:0]));
        check_eq("cout", 32'(cout[s]), 32'(exp_r[8]));
        for (int i = 0; i < hold; i++) begin
            in_valid[s] = 1'($urandom_range(0, 1));
            a[s] = 8'($urandom);
            @(posedge clk); #1;
            check_eq("bp_valid", 32'(out_valid[s]), 32'd1);
            check_eq("bp_sum", 32'(sum[s]), 32'(exp_r[7:0]));
            check_eq("bp_cout", 32'(cout[s]), 32'(exp_r[8]));
            check_eq("bp_in_ready", 32'(in_ready[s]), 32'd0);
        end
        in_valid[s]  = 1'($urandom_range(0, 1));
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        in_valid[s]  = 1'b0;
        out_ready[s] = 1'b0;
        check_eq("release_valid", 32'(out_valid[s]), 32'd0);
        check_eq("release_ready", 32'(in_ready[s]), 32'd1);
        @(posedge clk); #1;
        check_eq("no_extra_valid", 32'(out_valid[s]), 32'd0);
        check_eq("no_extra_ready", 32'(in_ready[s]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = '0; out_ready = '0; cin = '0;
        a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = '0;
`endif
        #2;
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_out_valid", 32'(out_valid[s]), 32'd0);
            check_eq("rst_sum", 32'(sum[s]), 32'd0);
            check_eq("rst_cout", 32'(cout[s]), 32'd0);
            check_eq("rst_in_ready", 32'(in_ready[s]), 32'd0);
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_ready0", 32'(in_ready[0]), 32'd1);
        check_eq("post_rst_ready1", 32'(in_ready[1]), 32'd1);

        do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1);
        do_op(0, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_op(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        do_op(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 20);
        do_op(1, 8'h81, 8'h7F, 1'b0, 1'b0, 20);
`ifdef SERIAL_ADDER_SUB_EN
        do_op(0, 8'h10, 8'h01, 1'b0, 1'b1, 0);
        do_op(0, 8'h00, 8'h01, 1'b0, 1'b1, 0);
        do_op(1, 8'h00, 8'h00, 1'b1, 1'b1, 0);
`endif
        for (int i = 0; i < 24; i++) begin
            logic ts;
`ifdef SERIAL_ADDER_SUB_EN
            ts = 1'($urandom_range(0, 1));
`else
            ts = 1'b0;
`endif
            do_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), ts,
                  int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of RUN
        a[0] = 8'hFF; b[0] = 8'hFF; cin[0] = 1'b1; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrun_valid", 32'(out_valid[0]), 32'd0);
        check_eq("midrun_sum", 32'(sum[0]), 32'd0);
        check_eq("midrun_cout", 32'(cout[0]), 32'd0);
        check_eq("midrun_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready_low", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check_eq("rel_ready_high", 32'(in_ready[0]), 32'd1);
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
